reaction_responder: RTL

Synthetic player that closes the loop around the reaction-time game for self-test and silicon bring-up. It watches the game's "go" LED output. After a programmable reaction delay it drives a button press with optional contact bounce and a programmable hold. It sits outside the game core: on the bench it feeds the button input, and on-chip it is muxed onto the button path in test mode. An early-press mode exercises the game's false-start path.

---
 rtl/reaction_responder.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/reaction_responder.sv
// -----------------------------------------------------------------------------
// reaction_responder
// Synthetic player for the reaction-time game. It watches the game's "go" LED,
// waits a programmable reaction delay, then drives a button press made of an
// optional burst of contact-bounce pulses followed by a stable hold. An early
// mode presses without waiting for the LED so the game's false-start path can
// be exercised.
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active-high
//   enable       responder active; low returns the block to IDLE
//   led_in       game "go" LED, same clock domain
//   early_mode   press without waiting for the LED
//   delay_cfg    reaction delay in cycles
//   hold_cfg     stable press length in cycles (0 behaves as 1)
//   bounce_cfg   number of bounce pulses ahead of the stable press
//   btn_out      registered button drive to the game
//   busy         high while in WAIT, BOUNCE or HOLD
//   done         one-cycle pulse as the final hold cycle ends
//   press_count  completed presses, wraps modulo 256
// -----------------------------------------------------------------------------
module reaction_responder #(
   parameter int DELAY_W  = 16,
   parameter int HOLD_W   = 8,
   parameter int BOUNCE_W = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic                led_in,
   input  logic                early_mode,
   input  logic [DELAY_W-1:0]  delay_cfg,
   input  logic [HOLD_W-1:0]   hold_cfg,
   input  logic [BOUNCE_W-1:0] bounce_cfg,
   output logic                btn_out,
   output logic                busy,
   output logic                done,
   output logic [7:0]          press_count
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ARMED   = 3'd1,
      S_WAIT    = 3'd2,
      S_BOUNCE  = 3'd3,
      S_HOLD    = 3'd4,
      S_RELEASE = 3'd5
   } state_t;

   // The bounce counter needs one extra bit: it is loaded with 2*bounce_cfg-1.
   localparam int BCNT_W = BOUNCE_W + 1;

   localparam logic [DELAY_W-1:0] DCNT_ZERO = {DELAY_W{1'b0}};
   localparam logic [DELAY_W-1:0] DCNT_ONE  = {{(DELAY_W-1){1'b0}}, 1'b1};
   localparam logic [BCNT_W-1:0]  BCNT_ZERO = {BCNT_W{1'b0}};
   localparam logic [BCNT_W-1:0]  BCNT_ONE  = {{(BCNT_W-1){1'b0}}, 1'b1};
   localparam logic [HOLD_W-1:0]  HCNT_ZERO = {HOLD_W{1'b0}};
   localparam logic [HOLD_W-1:0]  HCNT_ONE  = {{(HOLD_W-1){1'b0}}, 1'b1};
   localparam logic [BOUNCE_W-1:0] BCFG_ZERO = {BOUNCE_W{1'b0}};

   state_t              state_q, state_d;
   logic [DELAY_W-1:0]  dcnt_q, dcnt_d;
   logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
   logic [HOLD_W-1:0]   hcnt_q, hcnt_d;
   logic                led_q;
   logic                btn_q, btn_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [7:0]          count_q, count_d;

   logic                led_rise_s;
   logic [BCNT_W-1:0]   bcnt_load_s;
   logic [HOLD_W-1:0]   hcnt_load_s;

   assign led_rise_s  = led_in & ~led_q;
   // 2*bounce_cfg cycles in BOUNCE, counted down to zero inclusive.
   assign bcnt_load_s = {bounce_cfg, 1'b0} - BCNT_ONE;
   // max(hold_cfg,1) cycles in HOLD, counted down to zero inclusive.
   assign hcnt_load_s = (hold_cfg == HCNT_ZERO) ? HCNT_ZERO : (hold_cfg - HCNT_ONE);

   // State, counters, LED history and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         dcnt_q  <= DCNT_ZERO;
         bcnt_q  <= BCNT_ZERO;
         hcnt_q  <= HCNT_ZERO;
         led_q   <= 1'b0;
         btn_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         count_q <= 8'd0;
      end else begin
         state_q <= state_d;
         dcnt_q  <= dcnt_d;
         bcnt_q  <= bcnt_d;
         hcnt_q  <= hcnt_d;
         led_q   <= led_in;
         btn_q   <= btn_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         count_q <= count_d;
      end
   end

   // Next-state, counter and next-output logic; outputs follow the state being entered.
   always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      bcnt_d  = bcnt_q;
      hcnt_d  = hcnt_q;
      btn_d   = 1'b0;
      done_d  = 1'b0;
      count_d = count_q;

      if (!enable) begin
         // Abort: no done pulse, no count for a press cut short.
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = S_ARMED;
            end
            S_ARMED: begin
               if (early_mode || led_rise_s) begin
                  state_d = S_WAIT;
                  dcnt_d  = delay_cfg;
               end else begin
                  state_d = S_ARMED;
               end
            end
            S_WAIT: begin
               if (dcnt_q == DCNT_ZERO) begin
                  btn_d = 1'b1;
                  if (bounce_cfg != BCFG_ZERO) begin
                     state_d = S_BOUNCE;
                     bcnt_d  = bcnt_load_s;
                  end else begin
                     state_d = S_HOLD;
                     hcnt_d  = hcnt_load_s;
                  end
               end else begin
                  dcnt_d = dcnt_q - DCNT_ONE;
               end
            end
            S_BOUNCE: begin
               if (bcnt_q == BCNT_ZERO) begin
                  state_d = S_HOLD;
                  hcnt_d  = hcnt_load_s;
                  btn_d   = 1'b1;
               end else begin
                  // Odd count means the pulse is high now, so the next cycle is low.
                  bcnt_d = bcnt_q - BCNT_ONE;
                  btn_d  = ~bcnt_q[0];
               end
            end
            S_HOLD: begin
               if (hcnt_q == HCNT_ZERO) begin
                  state_d = S_RELEASE;
                  done_d  = 1'b1;
                  count_d = count_q + 8'd1;
               end else begin
                  hcnt_d = hcnt_q - HCNT_ONE;
                  btn_d  = 1'b1;
               end
            end
            S_RELEASE: begin
               // Waiting for the LED to drop prevents a second press on one LED pulse.
               if (early_mode || !led_in) begin
                  state_d = S_ARMED;
               end else begin
                  state_d = S_RELEASE;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      busy_d = (state_d == S_WAIT) || (state_d == S_BOUNCE) || (state_d == S_HOLD);
   end

   assign btn_out     = btn_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign press_count = count_q;

endmodule
